dsp_frame_loader: RTL and testbench



---
 rtl/dsp_frame_loader_pkg.sv | 37 +++
 rtl/frame_strobe_decoder.sv | 36 +++
 rtl/dsp_frame_loader.sv | 147 ++++++++++++++
 tb/tb_dsp_frame_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_frame_loader_pkg.sv
// Shared types, widths and helpers for the DSP supertile column frame loader.
package dsp_frame_loader_pkg;

  // Sequencer states. A frame walks WAIT_BOT -> WAIT_TOP -> STROBE -> GAP.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BOT = 3'd1,
    WAIT_TOP = 3'd2,
    STROBE   = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Width of a counter able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index selecting one of n items; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Widths for the default column height of 20 frames.
  localparam int MAX_FRAMES_PER_COL_DEF = 20;
  localparam int CW = cnt_width(MAX_FRAMES_PER_COL_DEF);
  localparam int IW = idx_width(MAX_FRAMES_PER_COL_DEF);

  // Strobe hold counter covers STROBE_CYCLES up to 15.
  localparam int HOLD_W = 4;

  // A load request is legal for 1..max_frames frames.
  function automatic logic count_legal(input int fc, input int max_frames);
    return (fc >= 1) && (fc <= max_frames);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder driving the supertile FrameStrobe bus.
module frame_strobe_decoder
  import dsp_frame_loader_pkg::*;
#(
  parameter int N     = MAX_FRAMES_PER_COL_DEF,
  parameter int IDX_W = IW
) (
  input  logic             UserCLK,
  input  logic             resetn,
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     strobe
);

  logic [N-1:0] onehot;

  // Decode the frame index into a single strobe bit, gated by the enable.
  always_comb begin
    // NOTE: default assignment first; without it a combinational block can infer a latch.
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

  // Strobe register; held at zero while reset is asserted.
  always_ff @(posedge UserCLK) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values, independent of block order.
    if (!resetn) begin
      strobe <= '0;
    end else begin
      strobe <= onehot;
    end
  end

endmodule

// File: rtl/dsp_frame_loader.sv
// Configuration sequencer for one DSP supertile column: takes a bot word and a
// top word per frame, presents them on the frame data rows, then pulses the
// frame's strobe bit and holds the data for one gap cycle afterwards.
module dsp_frame_loader
  import dsp_frame_loader_pkg::*;
#(
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int STROBE_CYCLES      = 1
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  input  logic                                    start,
  input  logic [$clog2(MAX_FRAMES_PER_COL+1)-1:0] frame_count,
  input  logic                                    abort,
  input  logic [FRAME_BITS_PER_ROW-1:0]           s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [FRAME_BITS_PER_ROW-1:0]           bot_frame_data,
  output logic [FRAME_BITS_PER_ROW-1:0]           top_frame_data,
  output logic [MAX_FRAMES_PER_COL-1:0]           frame_strobe,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);

  localparam int FCW = cnt_width(MAX_FRAMES_PER_COL);
  localparam int FIW = idx_width(MAX_FRAMES_PER_COL);

  state_t                        state_q, state_d;
  logic [FIW-1:0]                idx_q, idx_d;
  logic [FCW-1:0]                count_q, count_d;
  logic [HOLD_W-1:0]             hold_q, hold_d;
  logic [FRAME_BITS_PER_ROW-1:0] bot_d, top_d;
  logic                          err_d;
  logic                          strobe_en;

  // Words are only taken while waiting for one, and never in an abort cycle.
  assign s_ready = ((state_q == WAIT_BOT) || (state_q == WAIT_TOP)) && !abort;

  // Next-state and next-register values for the load sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    hold_d  = hold_q;
    bot_d   = bot_frame_data;
    top_d   = top_frame_data;
    err_d   = 1'b0;

    if ((state_q != IDLE) && abort) begin
      // Cancel from any active state; already strobed frames stay written.
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count_legal(int'(frame_count), MAX_FRAMES_PER_COL)) begin
              count_d = frame_count;
              idx_d   = '0;
              state_d = WAIT_BOT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WAIT_BOT: begin
          if (s_valid && s_ready) begin
            bot_d   = s_data;
            state_d = WAIT_TOP;
          end
        end
        WAIT_TOP: begin
          if (s_valid && s_ready) begin
            top_d   = s_data;
            hold_d  = '0;
            state_d = STROBE;
          end
        end
        STROBE: begin
          if (hold_q == HOLD_W'(STROBE_CYCLES - 1)) begin
            state_d = GAP;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        GAP: begin
          // Data is still held here so the supertile sees hold time after the strobe.
          if (FCW'(idx_q) == count_q - FCW'(1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + FIW'(1);
            state_d = WAIT_BOT;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // The strobe register follows the next state, so it is high exactly while in STROBE.
  assign strobe_en = (state_d == STROBE);

  frame_strobe_decoder #(
    .N     (MAX_FRAMES_PER_COL),
    .IDX_W (FIW)
  ) u_strobe (
    .UserCLK (UserCLK),
    .resetn  (resetn),
    .idx     (idx_d),
    .en      (strobe_en),
    .strobe  (frame_strobe)
  );

  // Sequencer state, frame data rows and registered status outputs.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      // NOTE: the data rows are reset as well, so the supertile sees zeros rather than X after reset.
      state_q        <= IDLE;
      idx_q          <= '0;
      count_q        <= '0;
      hold_q         <= '0;
      bot_frame_data <= '0;
      top_frame_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      count_q        <= count_d;
      hold_q         <= hold_d;
      bot_frame_data <= bot_d;
      top_frame_data <= top_d;
      busy           <= (state_d != IDLE);
      done           <= (state_d == DONE);
      err            <= err_d;
    end
  end

endmodule

// File: tb/tb_dsp_frame_loader.sv
// Scoreboard bench for dsp_frame_loader: random word streams, expected frames
// and terminal events queued at issue time, checked by an independent monitor.
module tb_dsp_frame_loader;

  localparam int MAXF = 20;
  localparam int BITS = 32;
  localparam int CW   = $clog2(MAXF + 1);

  typedef struct {
    int              idx;
    logic [BITS-1:0] bot;
    logic [BITS-1:0] top;
  } frame_t;

  typedef enum {EV_NONE, EV_DONE, EV_ERR} ev_t;

  logic            UserCLK;
  logic            resetn;
  logic            start, abort, s_valid, s_ready;
  logic [CW-1:0]   frame_count;
  logic [BITS-1:0] s_data, bot, top;
  logic [MAXF-1:0] frame_strobe;
  logic            busy, done, err;

  logic            start4, abort4, s_valid4, s_ready4;
  logic [CW-1:0]   frame_count4;
  logic [BITS-1:0] s_data4, bot4, top4;
  logic [MAXF-1:0] frame_strobe4;
  logic            busy4, done4, err4;

  int checks   = 0;
  int failures = 0;

  frame_t          exp_frames[$];
  ev_t             exp_ev[$];
  logic [BITS-1:0] word_q[$];
  int              accepted  = 0;
  int              stop_at   = -1;
  int              valid_pct = 100;

  dsp_frame_loader #(.MAX_FRAMES_PER_COL(MAXF), .FRAME_BITS_PER_ROW(BITS), .STROBE_CYCLES(1)) dut (
    .UserCLK(UserCLK), .resetn(resetn), .start(start), .frame_count(frame_count),
    .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bot_frame_data(bot), .top_frame_data(top), .frame_strobe(frame_strobe),
    .busy(busy), .done(done), .err(err));

  dsp_frame_loader #(.MAX_FRAMES_PER_COL(MAXF), .FRAME_BITS_PER_ROW(BITS), .STROBE_CYCLES(4)) dut4 (
    .UserCLK(UserCLK), .resetn(resetn), .start(start4), .frame_count(frame_count4),
    .abort(abort4), .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4),
    .bot_frame_data(bot4), .top_frame_data(top4), .frame_strobe(frame_strobe4),
    .busy(busy4), .done(done4), .err(err4));

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus acts 2 time units after the rising edge; the word driver acts at 1.
  task automatic step();
    @(posedge UserCLK);
    #2;
  endtask

  // Queue a load of n frames: all words go to the driver, the first n_strobed
  // frames are expected on the strobe bus, then the terminal event.
  task automatic plan_load(input int n, input int n_strobed, input ev_t ev);
    frame_t          f;
    logic [BITS-1:0] b, t;
    accepted = 0;
    for (int j = 0; j < n; j++) begin
      b = $urandom;
      t = $urandom;
      word_q.push_back(b);
      word_q.push_back(t);
      if (j < n_strobed) begin
        f.idx = j;
        f.bot = b;
        f.top = t;
        exp_frames.push_back(f);
      end
    end
    if (ev != EV_NONE) exp_ev.push_back(ev);
  endtask

  task automatic start_load(input int fc, input bit with_abort);
    frame_count = CW'(fc);
    start       = 1'b1;
    abort       = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // n counts clock edges from the start edge (start edge gives n=1).
  task automatic wait_done(input int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic wait_accepted(input int target, input int budget);
    int g = 0;
    while (accepted < target && g < budget) begin
      step();
      g++;
    end
    check("words_accepted", accepted, target);
  endtask

  // Word source: presents the head of word_q with random valid gaps, can stall at word stop_at.
  initial begin : driver
    bit hs;
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge UserCLK);
      hs = s_valid && s_ready;
      @(posedge UserCLK);
      #1;
      if (hs && word_q.size() > 0) begin
        void'(word_q.pop_front());
        accepted++;
      end
      if (word_q.size() > 0 && accepted != stop_at && $urandom_range(99) < valid_pct) begin
        s_valid = 1'b1;
        s_data  = word_q[0];
      end else begin
        s_valid = 1'b0;
        s_data  = $urandom;
      end
    end
  end

  // Monitor: compares strobes, data rows and terminal pulses against the queues.
  logic [MAXF-1:0] prev_s  = '0;
  logic [BITS-1:0] prev_b  = '0;
  logic [BITS-1:0] prev_t  = '0;
  int              hi_len  = 0;

  initial begin : monitor
    frame_t f;
    ev_t    ev;
    forever begin
      @(negedge UserCLK);
      check("strobe_onehot0", $onehot0(frame_strobe), 1);
      if (frame_strobe != '0 && prev_s == '0) begin
        if (exp_frames.size() == 0) begin
          check("unexpected_strobe", frame_strobe, 0);
        end else begin
          f = exp_frames.pop_front();
          check("strobe_bit", frame_strobe, MAXF'(1) << f.idx);
          check("bot_at_strobe", bot, f.bot);
          check("bot_before_strobe", prev_b, f.bot);
          check("top_at_strobe", top, f.top);
        end
        hi_len = 1;
      end else if (frame_strobe != '0) begin
        check("strobe_steady", frame_strobe, prev_s);
        check("bot_steady", bot, prev_b);
        check("top_steady", top, prev_t);
        hi_len++;
      end else if (prev_s != '0) begin
        check("strobe_len", hi_len, 1);
        check("gap_bot_hold", bot, prev_b);
        check("gap_top_hold", top, prev_t);
      end
      if (done || err) begin
        if (exp_ev.size() == 0) begin
          check("unexpected_done_err", {done, err}, 2'b00);
        end else begin
          ev = exp_ev.pop_front();
          check("terminal_pulse", {done, err}, (ev == EV_DONE) ? 2'b10 : 2'b01);
          if (done) check("frames_left_at_done", exp_frames.size(), 0);
        end
      end
      prev_s = frame_strobe;
      prev_b = bot;
      prev_t = top;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n, hi, first, dn, g;
    logic [BITS-1:0] w0, w1;

    resetn = 1'b0;
    start = 1'b0; abort = 1'b0; frame_count = '0;
    start4 = 1'b0; abort4 = 1'b0; frame_count4 = '0; s_valid4 = 1'b0; s_data4 = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_bot", bot, 0);
    check("rst_top", top, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_strobe4", frame_strobe4, 0);
    resetn = 1'b1;
    step();

    // Basic load of 2 frames, valid held high; abort alongside start must be ignored.
    valid_pct = 100;
    plan_load(2, 2, EV_DONE);
    start_load(2, 1'b1);
    check("start_beats_abort_busy", busy, 1);
    wait_done(100, n);
    check("basic_done_latency", n, 9);
    step();
    check("basic_busy_after", busy, 0);
    check("basic_done_one_cycle", done, 0);

    // Illegal frame counts 0 and 21.
    for (int k = 0; k < 2; k++) begin
      exp_ev.push_back(EV_ERR);
      start_load((k == 0) ? 0 : MAXF + 1, 1'b0);
      check("illegal_err", err, 1);
      check("illegal_busy", busy, 0);
      check("illegal_s_ready", s_ready, 0);
      check("illegal_strobe", frame_strobe, 0);
      step();
      check("illegal_err_one_cycle", err, 0);
    end

    // Abort while idle is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_no_err", err, 0);
    check("idle_abort_busy", busy, 0);

    // STROBE_CYCLES=4 instance, one frame.
    w0 = $urandom; w1 = $urandom;
    s_data4 = w0; s_valid4 = 1'b1; frame_count4 = CW'(1); start4 = 1'b1;
    step();
    start4 = 1'b0;
    n = 1; hi = 0; first = 0; dn = 0;
    while (n < 40 && dn == 0) begin
      if (n == 2) s_data4 = w1;
      if (n == 3) s_valid4 = 1'b0;
      step();
      n++;
      if (frame_strobe4 != '0) begin
        hi++;
        if (first == 0) first = n;
        check("sc4_strobe_bit", frame_strobe4, 1);
        check("sc4_bot", bot4, w0);
        check("sc4_top", top4, w1);
      end
      if (done4) dn = n;
    end
    check("sc4_strobe_cycles", hi, 4);
    check("sc4_strobe_first", first, 3);
    check("sc4_done_latency", dn, 8);

    // Full column with random valid gaps; a start pulse mid-load must be ignored.
    valid_pct = 60;
    plan_load(MAXF, MAXF, EV_DONE);
    start_load(MAXF, 1'b0);
    wait_accepted(10, 400);
    frame_count = CW'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_while_busy_busy", busy, 1);
    wait_done(2000, n);
    step();
    check("full_busy_after", busy, 0);

    // Abort in the STROBE cycle of frame 3.
    valid_pct = 100;
    plan_load(5, 4, EV_ERR);
    start_load(5, 1'b0);
    g = 0;
    while (!frame_strobe[3] && g < 200) begin
      step();
      g++;
    end
    check("reached_frame3_strobe", frame_strobe[3], 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_strobe_cut", frame_strobe, 0);
    check("abort_err", err, 1);
    check("abort_busy", busy, 0);
    check("abort_no_done", done, 0);
    word_q.delete();
    repeat (3) step();

    // Abort together with s_valid in WAIT_TOP: no word may be taken.
    stop_at = 1;
    plan_load(3, 0, EV_ERR);
    start_load(3, 1'b0);
    wait_accepted(1, 100);
    step();
    stop_at = -1;
    step();
    abort = 1'b1;
    #1;
    check("abort_wait_top_s_ready", s_ready, 0);
    step();
    abort = 1'b0;
    check("abort_wait_top_err", err, 1);
    check("abort_wait_top_busy", busy, 0);
    check("abort_wait_top_no_word", accepted, 1);
    word_q.delete();
    repeat (3) step();

    // Reset during WAIT_TOP of frame 5, then a fresh load from frame 0.
    valid_pct = 80;
    stop_at = 11;
    plan_load(8, 5, EV_NONE);
    start_load(8, 1'b0);
    wait_accepted(11, 600);
    repeat (2) step();
    check("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    step();
    check("midrst_strobe", frame_strobe, 0);
    check("midrst_bot", bot, 0);
    check("midrst_top", top, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_s_ready", s_ready, 0);
    resetn = 1'b1;
    word_q.delete();
    stop_at = -1;
    step();
    valid_pct = 100;
    plan_load(2, 2, EV_DONE);
    start_load(2, 1'b0);
    wait_done(100, n);
    check("reload_done_latency", n, 9);

    repeat (4) step();
    check("frames_left_end", exp_frames.size(), 0);
    check("events_left_end", exp_ev.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
